// File: rtl/qam_pkg.sv
// Shared definitions for the QAM symbol scheduler: modulation codes,
// bits-per-symbol lookup, default widths and the scheduler state enum.
package qam_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int AXIS_W_DEF = 6;

  localparam logic [2:0] MOD_2    = 3'd0;
  localparam logic [2:0] MOD_4    = 3'd1;
  localparam logic [2:0] MOD_16   = 3'd2;
  localparam logic [2:0] MOD_64   = 3'd3;
  localparam logic [2:0] MOD_256  = 3'd4;
  localparam logic [2:0] MOD_1024 = 3'd5;
  localparam logic [2:0] MOD_4096 = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // Reserved code 7 falls back to the 1-bit constellation.
  function automatic logic [3:0] bps_of(input logic [2:0] m);
    case (m)
      MOD_4:    return 4'd2;
      MOD_16:   return 4'd4;
      MOD_64:   return 4'd6;
      MOD_256:  return 4'd8;
      MOD_1024: return 4'd10;
      MOD_4096: return 4'd12;
      default:  return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/qam_sym_sched_if.sv
// Word-source and mapper handshakes of the QAM symbol scheduler.
interface qam_sym_sched_if #(
  parameter int DATA_W = 32,
  parameter int AXIS_W = 6
);
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              data_ready;
  logic [2:0]        modtyp;
  logic              flush;
  logic [AXIS_W-1:0] sym_i;
  logic [AXIS_W-1:0] sym_q;
  logic              sym_valid;
  logic              sym_ready;
  logic              dbufempt;
  logic              busy;

  modport master (
    output data, data_valid, modtyp, flush, sym_ready,
    input  data_ready, sym_i, sym_q, sym_valid, dbufempt, busy
  );

  modport slave (
    input  data, data_valid, modtyp, flush, sym_ready,
    output data_ready, sym_i, sym_q, sym_valid, dbufempt, busy
  );
endinterface

// File: rtl/qam_sym_sched_accum.sv
// 2*DATA_W bit accumulator: words append above the fill level, symbols pop
// from bit 0. Bits above the fill level are always zero, which gives free
// zero-padding of a short final symbol.
module qam_bit_accum #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 12,
  parameter int FILL_W = 7
) (
  input  logic              dclk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] word,
  input  logic              pop,
  input  logic [FILL_W-1:0] pop_n,
  output logic [FILL_W-1:0] fill_m,
  output logic [FILL_W-1:0] fill_nxt,
  output logic [OUT_W-1:0]  bits
);

  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] merged;
  logic [2*DATA_W-1:0] acc_nxt;
  logic [FILL_W-1:0]   fill;

  // Incoming word is merged before slicing so a symbol can leave the same cycle.
  always_comb begin
    merged = acc;
    fill_m = fill;
    if (push) begin
      merged = acc | ({{DATA_W{1'b0}}, word} << fill);
      fill_m = fill + FILL_W'(DATA_W);
    end
  end

  always_comb begin
    acc_nxt  = merged;
    fill_nxt = fill_m;
    if (pop) begin
      acc_nxt  = merged >> pop_n;
      fill_nxt = fill_m - pop_n;
    end
  end

  assign bits = merged[OUT_W-1:0];

  always_ff @(posedge dclk) begin
    if (rst) begin
      acc  <= '0;
      fill <= '0;
    end else begin
      acc  <= acc_nxt;
      fill <= fill_nxt;
    end
  end

endmodule

// File: rtl/qam_sym_sched.sv
// QAM symbol scheduler: slices accumulated data bits into I/Q indices.
// Build option QAM_SCHED_GRAY_EN adds a Gray-coded registered output stage.
module qam_sym_sched
  import qam_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AXIS_W = AXIS_W_DEF
) (
  input logic            dclk,
  input logic            rst,
  qam_sym_sched_if.slave bus
);

  localparam int FILL_W = $clog2(2*DATA_W + 1);
  localparam int OUT_W  = 2*AXIS_W;

  state_t              state, state_nxt;
  logic [3:0]          bps_r, bps_eff, bps_nxt;
  logic                push, take, pop, vld_nxt, s_ready;
  logic [FILL_W-1:0]   pop_n, fill_m, fill_nxt;
  logic [OUT_W-1:0]    bits;
  logic [AXIS_W-1:0]   sym_i_p0, sym_q_p0;
  logic                vld_p0;
  logic                data_ready_r, dbufempt_r;

  function automatic logic [OUT_W-1:0] pack(input logic [OUT_W-1:0] b, input logic [3:0] bps);
    logic [2:0]        half;
    logic [AXIS_W-1:0] mask;
    half = bps[3:1];
    mask = (AXIS_W'(1) << half) - AXIS_W'(1);
    if (bps == 4'd1) return {AXIS_W'(0), AXIS_W'(b[0])};
    return {AXIS_W'(b >> half) & mask, AXIS_W'(b) & mask};
  endfunction

  qam_bit_accum #(.DATA_W(DATA_W), .OUT_W(OUT_W), .FILL_W(FILL_W)) u_accum (
    .dclk     (dclk),
    .rst      (rst),
    .push     (push),
    .word     (bus.data),
    .pop      (pop),
    .pop_n    (pop_n),
    .fill_m   (fill_m),
    .fill_nxt (fill_nxt),
    .bits     (bits)
  );

  assign push    = bus.data_valid && data_ready_r;
  assign bps_eff = (state == IDLE) ? bps_of(bus.modtyp) : bps_r;
  assign bps_nxt = bps_eff;
  assign take    = !vld_p0 || s_ready;

  // In FLUSH a short remainder is popped whole; the zero bits above it pad the symbol.
  always_comb begin
    pop   = 1'b0;
    pop_n = FILL_W'(bps_eff);
    if (state == FLUSH) begin
      pop = take && (fill_m != '0);
      if (fill_m < FILL_W'(bps_eff)) pop_n = fill_m;
    end else begin
      pop = take && (fill_m >= FILL_W'(bps_eff));
    end
    vld_nxt = pop || (vld_p0 && !s_ready);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (push) state_nxt = bus.flush ? FLUSH : RUN;
      RUN:     if (bus.flush) state_nxt = FLUSH;
               else if (fill_nxt == '0 && !vld_nxt && !push) state_nxt = IDLE;
      FLUSH:   if (fill_nxt == '0 && !vld_nxt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: sliced symbol register and registered status flags
  always_ff @(posedge dclk) begin
    if (rst) begin
      state        <= IDLE;
      bps_r        <= 4'd1;
      vld_p0       <= 1'b0;
      sym_i_p0     <= '0;
      sym_q_p0     <= '0;
      data_ready_r <= 1'b0;
      dbufempt_r   <= 1'b1;
    end else begin
      state        <= state_nxt;
      bps_r        <= bps_nxt;
      vld_p0       <= vld_nxt;
      if (pop) {sym_q_p0, sym_i_p0} <= pack(bits, bps_eff);
      data_ready_r <= (state_nxt != FLUSH) && (fill_nxt <= FILL_W'(DATA_W));
      dbufempt_r   <= (fill_nxt < FILL_W'(bps_nxt)) && (state_nxt != FLUSH);
    end
  end

  assign bus.data_ready = data_ready_r;
  assign bus.dbufempt   = dbufempt_r;
  assign bus.busy       = (state != IDLE);

`ifdef QAM_SCHED_GRAY_EN
  logic [AXIS_W-1:0] sym_i_p1, sym_q_p1, skid_i, skid_q;
  logic              vld_p1, skid_vld;

  function automatic logic [AXIS_W-1:0] gray(input logic [AXIS_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  assign s_ready = !skid_vld;

  // Stage p1: Gray-coded output register; skid catches the symbol accepted while the mapper stalls
  always_ff @(posedge dclk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      skid_vld <= 1'b0;
      sym_i_p1 <= '0;
      sym_q_p1 <= '0;
      skid_i   <= '0;
      skid_q   <= '0;
    end else if (!vld_p1 || bus.sym_ready) begin
      if (skid_vld) begin
        sym_i_p1 <= skid_i;
        sym_q_p1 <= skid_q;
        vld_p1   <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) begin
          sym_i_p1 <= gray(sym_i_p0);
          sym_q_p1 <= gray(sym_q_p0);
        end
      end
    end else if (vld_p0 && !skid_vld) begin
      skid_i   <= gray(sym_i_p0);
      skid_q   <= gray(sym_q_p0);
      skid_vld <= 1'b1;
    end
  end

  assign bus.sym_i     = sym_i_p1;
  assign bus.sym_q     = sym_q_p1;
  assign bus.sym_valid = vld_p1;
`else
  assign s_ready       = bus.sym_ready;
  assign bus.sym_i     = sym_i_p0;
  assign bus.sym_q     = sym_q_p0;
  assign bus.sym_valid = vld_p0;
`endif

endmodule

// File: tb/tb_qam_sym_sched.sv
// Scoreboard bench for qam_sym_sched: stimulus queues expected I/Q pairs,
// a monitor compares every accepted symbol in order.
module tb_qam_sym_sched;

`ifdef QAM_SCHED_GRAY_EN
  localparam bit GRAY = 1'b1;
`else
  localparam bit GRAY = 1'b0;
`endif

  logic dclk = 1'b0;
  logic rst  = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic [11:0] exp_q[$];
  int          hs_cyc[$];

  qam_sym_sched_if #(.DATA_W(32), .AXIS_W(6)) bus ();

  qam_sym_sched #(.DATA_W(32), .AXIS_W(6)) dut (
    .dclk (dclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  always #5 dclk = ~dclk;
  always @(posedge dclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] gx(input logic [5:0] x);
    return GRAY ? (x ^ (x >> 1)) : x;
  endfunction

  task automatic exp_push(input int i, input int q);
    exp_q.push_back({gx(6'(q)), gx(6'(i))});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every symbol handshake pops and compares the next expected pair.
  always @(negedge dclk) begin
    if (!rst && bus.sym_valid && bus.sym_ready) begin
      checks++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_symbol: got I=%0d Q=%0d, expected none", bus.sym_i, bus.sym_q);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({bus.sym_q, bus.sym_i} !== e) begin
          errors++;
          $display("FAIL symbol: got I=%0d Q=%0d, expected I=%0d Q=%0d",
                   bus.sym_i, bus.sym_q, e[5:0], e[11:6]);
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input logic [2:0] m, input logic fl);
    int n = 0;
    bus.data = w; bus.data_valid = 1'b1; bus.modtyp = m; bus.flush = fl;
    @(negedge dclk);
    while (!bus.data_ready && n < 200) begin
      n++;
      @(negedge dclk);
    end
    if (!bus.data_ready) begin
      checks++; errors++;
      $display("FAIL word_accept: data_ready stuck at 0, expected 1");
    end
    @(posedge dclk); #1;
    bus.data_valid = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(posedge dclk); #1;
    bus.flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    @(negedge dclk);
    while ((exp_q.size() != 0 || bus.busy) && n < 2000) begin
      n++;
      @(negedge dclk);
    end
    chk({name, "_drain_left"}, exp_q.size(), 0);
    chk({name, "_busy_end"}, bus.busy, 0);
    @(posedge dclk); #1;
  endtask

  initial begin
    logic [31:0] w;
    bus.data = '0; bus.data_valid = 1'b0; bus.modtyp = 3'd0;
    bus.flush = 1'b0; bus.sym_ready = 1'b1;
    repeat (2) @(posedge dclk);
    #1;
    chk("rst_sym_valid", bus.sym_valid, 0);
    chk("rst_sym_iq", {bus.sym_i, bus.sym_q}, 0);
    chk("rst_data_ready", bus.data_ready, 0);
    chk("rst_dbufempt", bus.dbufempt, 1);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;

    // 16-QAM, 0xA5: (1,1), (2,2) then six zero symbols
    exp_push(1, 1); exp_push(2, 2);
    repeat (6) exp_push(0, 0);
    send_word(32'h0000_00A5, 3'd2, 1'b0);
    chk("first_sym_latency", bus.sym_valid, !GRAY);
    wait_drain("t1");
    chk("t1_dbufempt", bus.dbufempt, 1);

    // 64-QAM all ones with coincident flush: five (7,7), padded (3,0)
    repeat (5) exp_push(7, 7);
    exp_push(3, 0);
    send_word(32'hFFFF_FFFF, 3'd3, 1'b1);
    chk("t2_ready_in_flush", bus.data_ready, 0);
    chk("t2_busy_in_flush", bus.busy, 1);
    wait_drain("t2");

    // 2-QAM, two back-to-back words: 64 symbols without a bubble
    exp_push(1, 0);
    repeat (62) exp_push(0, 0);
    exp_push(1, 0);
    hs_cyc.delete();
    send_word(32'h0000_0001, 3'd0, 1'b0);
    send_word(32'h8000_0000, 3'd0, 1'b0);
    wait_drain("t3");
    chk("t3_count", hs_cyc.size(), 64);
    if (hs_cyc.size() == 64) chk("t3_no_bubble", hs_cyc[63] - hs_cyc[0], 63);

    // 4-QAM with a 5-cycle mapper stall
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 32'h1234_5678 : 32'h9ABC_DEF0;
      for (int b = 0; b < 16; b++) exp_push(int'(w[2*b]), int'(w[2*b+1]));
    end
    send_word(32'h1234_5678, 3'd1, 1'b0);
    send_word(32'h9ABC_DEF0, 3'd1, 1'b0);
    chk("t4_ready_when_full", bus.data_ready, 0);
    repeat (3) @(posedge dclk);
    #1;
    bus.sym_ready = 1'b0;
    begin
      logic [12:0] held;
      held = {bus.sym_valid, bus.sym_i, bus.sym_q};
      chk("t4_valid_in_stall", bus.sym_valid, 1);
      for (int c = 0; c < 5; c++) begin
        @(posedge dclk); #1;
        chk("t4_stall_hold", {bus.sym_valid, bus.sym_i, bus.sym_q}, held);
      end
    end
    bus.sym_ready = 1'b1;
    wait_drain("t4");

    // modtyp 2 -> 6 during RUN: nibbles keep 4-bit symbols
    w = 32'h7654_3210;
    for (int n = 0; n < 8; n++) exp_push(n & 3, n >> 2);
    send_word(w, 3'd2, 1'b0);
    bus.modtyp = 3'd6;
    wait_drain("t5a");
    // Next word in 4096-QAM: two full symbols, then an 8-bit residual
    exp_push(18, 60); exp_push(30, 51);
    send_word(32'hABCD_EF12, 3'd6, 1'b0);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        n++;
        @(negedge dclk);
      end
    end
    @(negedge dclk);
    chk("t5_starve_dbufempt", bus.dbufempt, 1);
    chk("t5_starve_busy", bus.busy, 1);
    chk("t5_starve_no_sym", bus.sym_valid, 0);
    @(posedge dclk); #1;
    exp_push(43, 2);
    pulse_flush();
    wait_drain("t5b");

    // Reset while stuck in FLUSH, then index 3 on both axes
    bus.sym_ready = 1'b0;
    send_word(32'hFFFF_FFFF, 3'd3, 1'b1);
    repeat (3) @(posedge dclk);
    #1;
    chk("t6_busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    @(posedge dclk); #1;
    rst = 1'b0;
    chk("t6_rst_sym_valid", bus.sym_valid, 0);
    chk("t6_rst_dbufempt", bus.dbufempt, 1);
    chk("t6_rst_busy", bus.busy, 0);
    bus.sym_ready = 1'b1;
    exp_push(3, 3);
    repeat (7) exp_push(0, 0);
    send_word(32'h0000_000F, 3'd2, 1'b0);
    wait_drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
